// File: rtl/fpcvt_sample_deser.sv
// Serial-to-parallel sample deserializer feeding the FP converter D input.
// Define FPCVT_DESER_PARITY_EN to append and check an even-parity bit per frame.
module fpcvt_sample_deser #(
    parameter int DATA_W = 12
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sdi,
    input  logic              sen,
    input  logic              rd_ack,
    output logic [DATA_W-1:0] d,
    output logic              d_valid,
    output logic              busy,
    output logic              frame_err,
    output logic              overrun,
    output logic              par_err
);

`ifdef FPCVT_DESER_PARITY_EN
    localparam int FRAME_LEN = DATA_W + 1;
`else
    localparam int FRAME_LEN = DATA_W;
`endif
    localparam int CNT_W = $clog2(FRAME_LEN + 1);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] sh_q, sh_d;
    logic [DATA_W-1:0] d_q, d_d;
    logic              dv_q, dv_d;
    logic              ferr_q, ferr_d;
    logic              ovr_q, ovr_d;

    logic [CNT_W-1:0]  cnt_nx;
    logic [DATA_W-1:0] base;
    logic [DATA_W-1:0] shifted;
    logic [DATA_W-1:0] word;
    logic              last;
    logic              par_ok;
    logic              perr_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sh_q    <= '0;
            d_q     <= '0;
            dv_q    <= 1'b0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sh_q    <= sh_d;
            d_q     <= d_d;
            dv_q    <= dv_d;
            ferr_q  <= ferr_d;
            ovr_q   <= ovr_d;
        end
    end

    // A fresh frame starts from an empty register so IDLE needs no clear.
    always_comb begin
        cnt_nx  = (state_q == IDLE) ? CNT_W'(1) : cnt_q + CNT_W'(1);
        base    = (state_q == IDLE) ? '0 : sh_q;
        shifted = (base << 1) | DATA_W'(sdi);
        last    = sen && (cnt_nx == CNT_W'(FRAME_LEN));
    end

`ifdef FPCVT_DESER_PARITY_EN
    // The final bit is parity, so the data word is already complete in sh_q.
    assign word   = sh_q;
    assign par_ok = ((^sh_q) == sdi);
`else
    assign word   = shifted;
    assign par_ok = 1'b1;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sh_d    = sh_q;
        d_d     = d_q;
        dv_d    = dv_q;
        ferr_d  = 1'b0;
        ovr_d   = ovr_q;
        perr_d  = 1'b0;

        if (rd_ack && dv_q) begin
            dv_d = 1'b0;
        end

        if (sen) begin
            if (last) begin
                state_d = IDLE;
                cnt_d   = '0;
                sh_d    = '0;
                if (par_ok) begin
                    if (!dv_q || rd_ack) begin
                        d_d  = word;
                        dv_d = 1'b1;
                    end else begin
                        ovr_d = 1'b1;
                    end
                end else begin
                    perr_d = 1'b1;
                end
            end else begin
                state_d = SHIFT;
                cnt_d   = cnt_nx;
                sh_d    = shifted;
            end
        end else if (state_q == SHIFT) begin
            state_d = IDLE;
            cnt_d   = '0;
            sh_d    = '0;
            ferr_d  = 1'b1;
        end
    end

`ifdef FPCVT_DESER_PARITY_EN
    logic perr_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perr_q <= 1'b0;
        end else begin
            perr_q <= perr_d;
        end
    end

    assign par_err = perr_q;
`else
    logic unused_perr;
    assign unused_perr = perr_d;
    assign par_err     = 1'b0;
`endif

    assign d         = d_q;
    assign d_valid   = dv_q;
    assign busy      = (state_q == SHIFT);
    assign frame_err = ferr_q;
    assign overrun   = ovr_q;

endmodule

// File: tb/tb_fpcvt_sample_deser.sv
// Scoreboard bench for fpcvt_sample_deser: directed frames, monitor on d/d_valid.
// Build with FPCVT_DESER_PARITY_EN to exercise the parity path as well.
module tb_fpcvt_sample_deser;

    logic        clk;
    logic        rst_n;
    logic        sdi;
    logic        sen;
    logic        rd_ack;
    logic [11:0] d;
    logic        d_valid;
    logic        busy;
    logic        frame_err;
    logic        overrun;
    logic        par_err;

    int checks = 0;
    int errors = 0;

    logic [11:0] exp_q[$];
    logic        prev_dv;
    logic        prev_ack;

    fpcvt_sample_deser #(.DATA_W(12)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .sdi       (sdi),
        .sen       (sen),
        .rd_ack    (rd_ack),
        .d         (d),
        .d_valid   (d_valid),
        .busy      (busy),
        .frame_err (frame_err),
        .overrun   (overrun),
        .par_err   (par_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [11:0] act,
                         input logic [11:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [11:0] w, input logic pbit,
                              input logic ack_last);
        for (int i = 11; i >= 0; i--) begin
            sen = 1'b1;
            sdi = w[i];
`ifdef FPCVT_DESER_PARITY_EN
            rd_ack = 1'b0;
`else
            rd_ack = (i == 0) ? ack_last : 1'b0;
`endif
            tick();
        end
`ifdef FPCVT_DESER_PARITY_EN
        sdi    = pbit;
        rd_ack = ack_last;
        tick();
`else
        if (pbit === 1'bx) $display("note: parity bit unused");
`endif
        sen    = 1'b0;
        sdi    = 1'b0;
        rd_ack = 1'b0;
    endtask

    task automatic ack_once();
        rd_ack = 1'b1;
        tick();
        rd_ack = 1'b0;
    endtask

    // A new word is on d when d_valid rises or a load coincided with rd_ack.
    initial begin
        prev_dv  = 1'b0;
        prev_ack = 1'b0;
        forever begin
            @(negedge clk);
            if (d_valid && (!prev_dv || prev_ack)) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_word: got %h expected none", d);
                end else begin
                    logic [11:0] e;
                    e = exp_q.pop_front();
                    if (d !== e) begin
                        errors++;
                        $display("FAIL word: got %h expected %h", d, e);
                    end
                end
            end
            prev_dv  = d_valid;
            prev_ack = rd_ack;
        end
    end

    initial begin
        logic [11:0] w;
        rst_n  = 1'b0;
        sen    = 1'b0;
        sdi    = 1'b0;
        rd_ack = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_d", d, 12'h000);
        check("rst_dv", {11'h0, d_valid}, 12'h0);
        check("rst_busy", {11'h0, busy}, 12'h0);
        check("rst_ovr", {11'h0, overrun}, 12'h0);
        check("rst_ferr", {11'h0, frame_err}, 12'h0);
        check("rst_perr", {11'h0, par_err}, 12'h0);
        rst_n = 1'b1;
        tick();

        w = 12'h7FF;
        exp_q.push_back(w);
        send_frame(w, ^w, 1'b0);
        @(negedge clk);
        check("max_dv", {11'h0, d_valid}, 12'h1);
        check("max_busy", {11'h0, busy}, 12'h0);
        check("max_d", d, 12'h7FF);
        #1;
        ack_once();
        @(negedge clk);
        check("ack_clr_dv", {11'h0, d_valid}, 12'h0);
        #1;

        w = 12'h800;
        exp_q.push_back(w);
        send_frame(w, ^w, 1'b0);
        w = 12'hFF6;
        exp_q.push_back(w);
        send_frame(w, ^w, 1'b1);
        @(negedge clk);
        check("b2b_d", d, 12'hFF6);
        check("b2b_dv", {11'h0, d_valid}, 12'h1);
        check("b2b_ovr", {11'h0, overrun}, 12'h0);
        #1;
        ack_once();

        w = 12'hA5A;
        for (int i = 11; i >= 7; i--) begin
            sen = 1'b1;
            sdi = w[i];
            tick();
        end
        @(negedge clk);
        check("mid_busy", {11'h0, busy}, 12'h1);
        #1;
        sen = 1'b0;
        tick();
        @(negedge clk);
        check("ferr_pulse", {11'h0, frame_err}, 12'h1);
        check("ferr_idle", {11'h0, busy}, 12'h0);
        check("ferr_d", d, 12'hFF6);
        check("ferr_dv", {11'h0, d_valid}, 12'h0);
        #1;
        tick();
        @(negedge clk);
        check("ferr_end", {11'h0, frame_err}, 12'h0);
        #1;

        w = 12'h02C;
        exp_q.push_back(w);
        send_frame(w, ^w, 1'b0);
        w = 12'h02D;
        send_frame(w, ^w, 1'b0);
        @(negedge clk);
        check("ovr_d", d, 12'h02C);
        check("ovr_set", {11'h0, overrun}, 12'h1);
        #1;
        ack_once();
        repeat (3) tick();
        @(negedge clk);
        check("ovr_sticky", {11'h0, overrun}, 12'h1);
        #1;

        w = 12'h5C3;
        for (int i = 11; i >= 5; i--) begin
            sen = 1'b1;
            sdi = w[i];
            tick();
        end
        rst_n = 1'b0;
        sen   = 1'b0;
        #1;
        check("arst_busy", {11'h0, busy}, 12'h0);
        check("arst_d", d, 12'h000);
        check("arst_ovr", {11'h0, overrun}, 12'h0);
        check("arst_ferr", {11'h0, frame_err}, 12'h0);
        tick();
        rst_n = 1'b1;
        w = 12'h1A0;
        exp_q.push_back(w);
        send_frame(w, ^w, 1'b0);
        @(negedge clk);
        check("post_rst_d", d, 12'h1A0);
        check("post_rst_ferr", {11'h0, frame_err}, 12'h0);
        #1;
        ack_once();

`ifdef FPCVT_DESER_PARITY_EN
        w = 12'h001;
        send_frame(w, 1'b0, 1'b0);
        @(negedge clk);
        check("perr_pulse", {11'h0, par_err}, 12'h1);
        check("perr_dv", {11'h0, d_valid}, 12'h0);
        check("perr_d", d, 12'h1A0);
        #1;
        tick();
        @(negedge clk);
        check("perr_end", {11'h0, par_err}, 12'h0);
        #1;
        exp_q.push_back(w);
        send_frame(w, 1'b1, 1'b0);
        @(negedge clk);
        check("par_ok_d", d, 12'h001);
        check("par_ok_perr", {11'h0, par_err}, 12'h0);
        #1;
`endif

        repeat (3) tick();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL pending_words: got %0d expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fpcvt_sample_deser.md
FPCVT_SAMPLE_DESER -- requirements
Module: fpcvt_sample_deser

Interface
REQ-001 The block SHALL have parameter DATA_W, default 12, giving the assembled word width (matches the FP converter D input).
REQ-002 The block SHALL have port clk  input  1  system clock; all state updates on the rising edge.
REQ-003 The block SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-004 The block SHALL have port sdi  input  1  serial data, MSB first, sampled on clk when sen=1.
REQ-005 The block SHALL have port sen  input  1  frame enable; high for every bit of a frame.
REQ-006 The block SHALL have port rd_ack  input  1  downstream has consumed d this cycle.
REQ-007 The block SHALL have port d  output  DATA_W  last complete two's-complement word, registered.
REQ-008 The block SHALL have port d_valid  output  1  d holds an unconsumed word.
REQ-009 The block SHALL have port busy  output  1  frame in progress (state SHIFT).
REQ-010 The block SHALL have port frame_err  output  1  one-cycle pulse: frame aborted.
REQ-011 The block SHALL have port overrun  output  1  sticky: a completed word was dropped.
REQ-012 The block SHALL have port par_err  output  1  one-cycle pulse: parity failure.

Function
REQ-013 The FSM SHALL have two states: IDLE and SHIFT; FRAME_LEN = DATA_W bits, or DATA_W+1 bits with parity (REQ-030).
REQ-014 In IDLE with sen=1, the block SHALL sample sdi as the first bit, set bit count to 1, and go to SHIFT.
REQ-015 In IDLE with sen=0, the block SHALL hold all state.
REQ-016 In SHIFT with sen=1, the block SHALL shift sdi into the LSB of the shift register and increment the count.
REQ-017 On the edge that samples bit FRAME_LEN, the word SHALL complete and the FSM SHALL return to IDLE.
REQ-018 On completion with d_valid=0, or d_valid=1 and rd_ack=1 on the same edge, d SHALL load the word and d_valid SHALL be 1 after that edge (zero added latency).
REQ-019 On completion with d_valid=1 and rd_ack=0, the new word SHALL be dropped, d SHALL stay unchanged, and overrun SHALL set.
REQ-020 rd_ack with d_valid=1 and no completion SHALL clear d_valid on the next edge; rd_ack with d_valid=0 SHALL be ignored.
REQ-021 In SHIFT with sen=0, the block SHALL discard the partial word, pulse frame_err for one cycle, and return to IDLE; d and d_valid are unaffected.
REQ-022 sen=1 on the cycle after completion SHALL start a new frame from IDLE; back-to-back frames have no gap.
REQ-023 busy SHALL be 1 exactly while the state is SHIFT.
REQ-024 overrun SHALL clear only on reset.

Reset
REQ-025 rst_n=0 SHALL immediately force IDLE, count 0, shift register 0, d=0, d_valid=0, frame_err=0, overrun=0, par_err=0.
REQ-026 Reset asserted mid-frame SHALL discard the partial frame with no frame_err pulse.
REQ-027 After rst_n deasserts, the first sampling edge SHALL be the first rising clk with rst_n=1.

Configuration
REQ-028 Macro FPCVT_DESER_PARITY_EN SHALL select the parity feature.
REQ-029 Without the macro, FRAME_LEN=DATA_W and par_err SHALL be tied 0.
REQ-030 With the macro, FRAME_LEN=DATA_W+1. The last bit is even parity over the DATA_W data bits. On mismatch, the word SHALL be discarded (d, d_valid, and overrun unchanged) and par_err SHALL pulse for one cycle on the completion edge.

Verification
REQ-031 Shift 12'h7FF (2047), sen high for 12 cycles -> d=12'h7FF, d_valid=1 after the 12th edge, busy=0.
REQ-032 Shift 12'h800 (-2048), then 12'hFF6 (-10) back-to-back with rd_ack pulsed on the completion edge of the second frame -> d=12'hFF6, d_valid stays 1, overrun=0.
REQ-033 Drop sen after 5 bits -> frame_err one-cycle pulse, state IDLE, d unchanged.
REQ-034 Complete 12'h02C (44), then complete 12'h02D (45) without rd_ack -> d=12'h02C, overrun=1 until reset.
REQ-035 Assert rst_n=0 mid-frame after 7 bits -> all outputs 0 immediately; the next full frame 12'h1A0 (416) is received correctly.
REQ-036 With FPCVT_DESER_PARITY_EN, send 12'h001 with parity bit 0 -> par_err pulse, d_valid=0; send 12'h001 with parity bit 1 -> d=12'h001.
